n_way_cache_fsm: RTL and testbench



---
 rtl/n_way_cache_fsm_if.sv | 57 +++++
 rtl/n_way_cache_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_n_way_cache_fsm.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/n_way_cache_fsm_if.sv
// Shared types and the request/response bundle between the processor-side
// memory wrapper and the n-way cache controller core.
//
// nway_cache_def : geometry constants and the four bus structs.
// n_way_cache_fsm_if :
//   cpu_req  - wrapper -> cache  {addr, data, rw (1 = store), valid}
//   mem_data - wrapper -> cache  {data, ready} memory completion
//   mem_req  - cache -> wrapper  {addr, data, rw (1 = write-back), valid}
//   cpu_res  - cache -> wrapper  {data, ready (hit), checked}
//   modport master : wrapper side, modport slave : cache side.

package nway_cache_def;
  localparam int ADDR_WIDTH   = 16;
  localparam int DATA_WIDTH   = 32;
  localparam int CACHE_BLOCKS = 64;
  localparam int WAYS         = 4;
  localparam int INDEX_W      = $clog2(CACHE_BLOCKS);
  localparam int TAG_W        = ADDR_WIDTH - INDEX_W - 2;
  localparam int WAY_W        = $clog2(WAYS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  rw;
    logic                  valid;
  } cpu_req_type;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
  } mem_data_type;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  rw;
    logic                  valid;
  } mem_req_type;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
    logic                  checked;
  } cpu_result_type;
endpackage

interface n_way_cache_fsm_if;
  import nway_cache_def::*;

  cpu_req_type    cpu_req;
  mem_data_type   mem_data;
  mem_req_type    mem_req;
  cpu_result_type cpu_res;

  modport master (output cpu_req, output mem_data, input mem_req, input cpu_res);
  modport slave  (input cpu_req, input mem_data, output mem_req, output cpu_res);
endinterface

// File: rtl/n_way_cache_fsm.sv
// Set-associative, write-back, write-allocate cache controller core with one
// word per line. Looks up one CPU request at a time, answers hit/miss in a
// single COMPARE_TAG cycle and, on a miss, asks the wrapper for a victim
// write-back and/or line fill.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   bus               n_way_cache_fsm_if.slave (cpu_req, mem_data in; mem_req, cpu_res out)
//   recheck_necessary one-cycle pulse in the cycle after an array line is written
//   index_affected    set index of the last array write
//   data_read_o       last word returned on a load hit
//   data_write_o      last word written into the data array

module n_way_cache_fsm
  import nway_cache_def::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  n_way_cache_fsm_if.slave      bus,
  output logic                  recheck_necessary,
  output logic [INDEX_W-1:0]    index_affected,
  output logic [DATA_WIDTH-1:0] data_read_o,
  output logic [DATA_WIDTH-1:0] data_write_o
);

  typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} state_t;

  state_t                         state_reg, state_next;
  logic [ADDR_WIDTH-1:0]          req_addr_reg;
  logic [DATA_WIDTH-1:0]          req_data_reg;
  logic                           req_rw_reg;
  logic [WAYS-1:0]                valid_reg [CACHE_BLOCKS];
  logic [WAYS-1:0]                dirty_reg [CACHE_BLOCKS];
  logic [WAY_W-1:0]               rr_reg    [CACHE_BLOCKS];
  logic [WAY_W-1:0]               victim_reg;
  mem_req_type                    wb_req_reg;
  logic [DATA_WIDTH-1:0]          cpu_data_reg;

  logic [WAYS-1:0][TAG_W-1:0]      way_tag;
  logic [WAYS-1:0][DATA_WIDTH-1:0] way_data;
  logic [WAYS-1:0]                way_we;

  logic                  lookup;
  logic [INDEX_W-1:0]    lookup_index, req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [WAYS-1:0]       set_valid, set_dirty;
  logic                  hit, has_invalid;
  logic [WAY_W-1:0]      hit_way, invalid_way, victim_way;
  mem_req_type           victim_req, mem_req_c;
  cpu_result_type        cpu_res_c;
  logic                  store_hit_we, load_hit, miss, fill_we, array_we;
  logic [DATA_WIDTH-1:0] wr_data;

  assign lookup       = (state_reg == IDLE) && bus.cpu_req.valid;
  assign lookup_index = bus.cpu_req.addr[INDEX_W+1:2];
  assign req_index    = req_addr_reg[INDEX_W+1:2];
  assign req_tag      = req_addr_reg[ADDR_WIDTH-1:INDEX_W+2];
  assign set_valid    = valid_reg[req_index];
  assign set_dirty    = dirty_reg[req_index];

  // Scanning from the top down leaves the lowest-numbered match in place.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    invalid_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_valid[w] && (way_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!set_valid[w]) begin
        has_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
    victim_way = has_invalid ? invalid_way : rr_reg[req_index];
  end

  always_comb begin
    victim_req.addr  = {way_tag[victim_way], req_index, 2'b00};
    victim_req.data  = way_data[victim_way];
    victim_req.rw    = set_valid[victim_way] & set_dirty[victim_way];
    victim_req.valid = 1'b1;
  end

  assign store_hit_we = (state_reg == COMPARE_TAG) && hit && req_rw_reg;
  assign load_hit     = (state_reg == COMPARE_TAG) && hit && !req_rw_reg;
  assign miss         = (state_reg == COMPARE_TAG) && !hit;
  assign fill_we      = (state_reg == ALLOCATE) && bus.mem_data.ready;
  assign array_we     = store_hit_we | fill_we;
  assign wr_data      = fill_we ? bus.mem_data.data : req_data_reg;

  // Tag/data storage per way. The set is read at the edge that latches the
  // request, so the registered read is ready for the COMPARE_TAG cycle.
  // Writes only happen at the end of COMPARE_TAG or ALLOCATE, never at a
  // lookup edge, so no read-during-write case exists.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : gen_way
      logic [TAG_W-1:0]      tag_mem  [CACHE_BLOCKS];
      logic [DATA_WIDTH-1:0] data_mem [CACHE_BLOCKS];
      logic [TAG_W-1:0]      tag_rd_reg;
      logic [DATA_WIDTH-1:0] data_rd_reg;

      assign way_we[gi] = (store_hit_we && (hit_way == WAY_W'(gi))) ||
                          (fill_we && (victim_reg == WAY_W'(gi)));

      always_ff @(posedge clk_i) begin
        if (way_we[gi]) begin
          tag_mem[req_index]  <= req_tag;
          data_mem[req_index] <= wr_data;
        end
        if (lookup) begin
          tag_rd_reg  <= tag_mem[lookup_index];
          data_rd_reg <= data_mem[lookup_index];
        end
      end

      assign way_tag[gi]  = tag_rd_reg;
      assign way_data[gi] = data_rd_reg;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= IDLE;
      req_addr_reg      <= '0;
      req_data_reg      <= '0;
      req_rw_reg        <= 1'b0;
      victim_reg        <= '0;
      wb_req_reg        <= '0;
      cpu_data_reg      <= '0;
      data_read_o       <= '0;
      data_write_o      <= '0;
      index_affected    <= '0;
      recheck_necessary <= 1'b0;
      for (int s = 0; s < CACHE_BLOCKS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        rr_reg[s]    <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (lookup) begin
        req_addr_reg <= bus.cpu_req.addr;
        req_data_reg <= bus.cpu_req.data;
        req_rw_reg   <= bus.cpu_req.rw;
      end
      if (miss) begin
        victim_reg <= victim_way;
        wb_req_reg <= victim_req;
        // The pointer only advances when it actually chose the victim.
        if (!has_invalid) begin
          rr_reg[req_index] <= rr_reg[req_index] + WAY_W'(1);
        end
      end
      if (store_hit_we) begin
        dirty_reg[req_index][hit_way] <= 1'b1;
      end
      if (fill_we) begin
        valid_reg[req_index][victim_reg] <= 1'b1;
        dirty_reg[req_index][victim_reg] <= req_rw_reg;
      end
      if (load_hit) begin
        cpu_data_reg <= way_data[hit_way];
        data_read_o  <= way_data[hit_way];
      end
      recheck_necessary <= array_we;
      if (array_we) begin
        index_affected <= req_index;
        data_write_o   <= wr_data;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    mem_req_c         = '0;
    cpu_res_c.data    = cpu_data_reg;
    cpu_res_c.ready   = 1'b0;
    cpu_res_c.checked = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cpu_req.valid) state_next = COMPARE_TAG;
      end
      COMPARE_TAG: begin
        cpu_res_c.checked = 1'b1;
        cpu_res_c.ready   = hit;
        if (hit) begin
          state_next = IDLE;
        end else begin
          mem_req_c  = victim_req;
          state_next = victim_req.rw ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req_c = wb_req_reg;
        if (bus.mem_data.ready) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_c.addr  = req_addr_reg;
        mem_req_c.data  = req_data_reg;
        mem_req_c.rw    = 1'b0;
        mem_req_c.valid = 1'b1;
        if (bus.mem_data.ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_req = mem_req_c;
  assign bus.cpu_res = cpu_res_c;

endmodule

// File: tb/tb_n_way_cache_fsm.sv
// Self-checking bench for n_way_cache_fsm: directed test-plan scenarios with
// literal expectations, then randomized traffic, all compared cycle by cycle
// against a behavioural set/way model of the cache.

module tb_n_way_cache_fsm;
  import nway_cache_def::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  n_way_cache_fsm_if bus_if ();
  logic        recheck;
  logic [5:0]  idx_aff;
  logic [31:0] drd, dwr;

  n_way_cache_fsm dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .bus               (bus_if),
    .recheck_necessary (recheck),
    .index_affected    (idx_aff),
    .data_read_o       (drd),
    .data_write_o      (dwr)
  );

  // ---------------- behavioural model ----------------
  bit          m_valid [64][4];
  bit          m_dirty [64][4];
  logic [7:0]  m_tag   [64][4];
  logic [31:0] m_data  [64][4];
  int          m_rr    [64];
  logic [31:0] m_cpu_data, m_write;
  logic [5:0]  m_index;
  bit          m_recheck;
  // effects that become visible after the next rising edge
  bit          wr_pend, rd_pend;
  logic [5:0]  wr_idx_p;
  logic [31:0] wr_data_p, rd_data_p;

  // expectations for the current cycle
  bit          chk_en = 1'b0;
  bit          e_checked, e_ready, e_mvalid, e_mrw, e_addr_en, e_data_en;
  logic [15:0] e_maddr;
  logic [31:0] e_mdata;

  // observations from the last COMPARE_TAG cycle
  logic        obs_ready, obs_mrw;
  logic [15:0] obs_maddr;
  logic [31:0] obs_mdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_cpu_data = '0; m_write = '0; m_index = '0; m_recheck = 1'b0;
    wr_pend = 1'b0; rd_pend = 1'b0;
  endtask

  task automatic set_idle_exp();
    e_checked = 1'b0; e_ready = 1'b0; e_mvalid = 1'b0; e_mrw = 1'b0;
    e_addr_en = 1'b0; e_data_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_recheck = wr_pend;
    if (wr_pend) begin
      m_index = wr_idx_p;
      m_write = wr_data_p;
    end
    if (rd_pend) m_cpu_data = rd_data_p;
    wr_pend = 1'b0;
    rd_pend = 1'b0;
  endtask

  // the single per-cycle compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("checked",   32'(bus_if.cpu_res.checked), 32'(e_checked));
      chk("hit_ready", 32'(bus_if.cpu_res.ready),   32'(e_ready));
      chk("mem_valid", 32'(bus_if.mem_req.valid),   32'(e_mvalid));
      if (e_mvalid)  chk("mem_rw",   32'(bus_if.mem_req.rw),   32'(e_mrw));
      if (e_addr_en) chk("mem_addr", 32'(bus_if.mem_req.addr), 32'(e_maddr));
      if (e_data_en) chk("mem_data", bus_if.mem_req.data, e_mdata);
      chk("cpu_data",   bus_if.cpu_res.data, m_cpu_data);
      chk("data_read",  drd, m_cpu_data);
      chk("data_write", dwr, m_write);
      chk("index_aff",  32'(idx_aff), 32'(m_index));
      chk("recheck",    32'(recheck), 32'(m_recheck));
      if (bus_if.cpu_res.checked) begin
        obs_ready = bus_if.cpu_res.ready;
        obs_mrw   = bus_if.mem_req.rw;
        obs_maddr = bus_if.mem_req.addr;
        obs_mdata = bus_if.mem_req.data;
      end
    end
  end

  // One full transaction starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_req(input logic [15:0] addr, input logic rw, input logic [31:0] wdata,
                        input logic [31:0] fill, input bit rst_mid);
    logic [5:0] idx;
    logic [7:0] tg;
    int hw, v, n;
    bit wb;
    idx = addr[7:2];
    tg  = addr[15:8];
    // IDLE: present the request (mem_data.ready noise is ignored here)
    set_idle_exp();
    bus_if.cpu_req = '{addr: addr, data: wdata, rw: rw, valid: 1'b1};
    bus_if.mem_data.ready = 1'($urandom % 2);
    bus_if.mem_data.data  = $urandom;
    step();
    // COMPARE_TAG
    bus_if.cpu_req.valid  = 1'b0;
    bus_if.mem_data.ready = 1'($urandom % 2);
    hw = -1;
    for (int w = 0; w < 4; w++)
      if (hw < 0 && m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    e_checked = 1'b1;
    e_ready   = (hw >= 0);
    if (hw >= 0) begin
      if (rw) begin
        m_data[idx][hw] = wdata;
        m_dirty[idx][hw] = 1'b1;
        wr_pend = 1'b1; wr_idx_p = idx; wr_data_p = wdata;
      end else begin
        rd_pend = 1'b1; rd_data_p = m_data[idx][hw];
      end
      step();
    end else begin
      v = -1;
      for (int w = 0; w < 4; w++)
        if (v < 0 && !m_valid[idx][w]) v = w;
      if (v < 0) begin
        v = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % 4;
      end
      wb = m_valid[idx][v] && m_dirty[idx][v];
      e_mvalid  = 1'b1;
      e_mrw     = wb;
      e_addr_en = m_valid[idx][v];
      e_data_en = m_valid[idx][v];
      e_maddr   = {m_tag[idx][v], idx, 2'b00};
      e_mdata   = m_data[idx][v];
      step();
      e_checked = 1'b0;
      e_ready   = 1'b0;
      if (wb) begin
        n = $urandom % 3;
        for (int i = 0; i <= n; i++) begin
          bus_if.mem_data.ready = (i == n);
          bus_if.mem_data.data  = $urandom;
          step();
        end
      end
      // ALLOCATE
      e_mvalid = 1'b1; e_mrw = 1'b0;
      e_addr_en = 1'b1; e_maddr = addr; e_data_en = 1'b0;
      if (rst_mid) begin
        bus_if.mem_data.ready = 1'b0;
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_checked",   32'(bus_if.cpu_res.checked), 32'd0);
        chk("rst_mem_valid", 32'(bus_if.mem_req.valid),   32'd0);
        chk("rst_cpu_data",  bus_if.cpu_res.data, 32'd0);
        chk("rst_data_read", drd, 32'd0);
        chk("rst_data_write", dwr, 32'd0);
        chk("rst_index",     32'(idx_aff), 32'd0);
        chk("rst_recheck",   32'(recheck), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        return;
      end
      n = $urandom % 3;
      for (int i = 0; i <= n; i++) begin
        bus_if.mem_data.ready = (i == n);
        bus_if.mem_data.data  = (i == n) ? fill : $urandom;
        if (i == n) begin
          m_valid[idx][v] = 1'b1;
          m_dirty[idx][v] = rw;
          m_tag[idx][v]   = tg;
          m_data[idx][v]  = fill;
          wr_pend = 1'b1; wr_idx_p = idx; wr_data_p = fill;
        end
        step();
      end
    end
    set_idle_exp();
    bus_if.mem_data.ready = 1'($urandom % 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int idx_opts [4];
    logic [15:0] a;
    logic [31:0] wd;
    logic r;
    idx_opts = '{1, 2, 5, 63};
    bus_if.cpu_req  = '0;
    bus_if.mem_data = '0;
    model_reset();
    set_idle_exp();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_checked",   32'(bus_if.cpu_res.checked), 32'd0);
    chk("reset_mem_valid", 32'(bus_if.mem_req.valid),   32'd0);
    chk("reset_cpu_data",  bus_if.cpu_res.data, 32'd0);
    chk("reset_recheck",   32'(recheck), 32'd0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // cold load miss, then reload hit
    do_req(16'h0104, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("cold_miss_ready", 32'(obs_ready), 32'd0);
    chk("cold_miss_rw",    32'(obs_mrw),   32'd0);
    do_req(16'h0104, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reload_hit",  32'(obs_ready), 32'd1);
    chk("reload_data", bus_if.cpu_res.data, 32'hDEADBEEF);

    // store hit
    do_req(16'h0104, 1'b1, 32'h12345678, 32'h0, 1'b0);
    chk("store_hit",     32'(obs_ready), 32'd1);
    chk("store_recheck", 32'(recheck), 32'd1);
    chk("store_index",   32'(idx_aff), 32'd1);
    do_req(16'h0104, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("store_readback", bus_if.cpu_res.data, 32'h12345678);

    // dirty eviction, then clean eviction in set 1
    do_req(16'h0204, 1'b0, 32'h0, 32'h22222222, 1'b0);
    do_req(16'h0304, 1'b0, 32'h0, 32'h33333333, 1'b0);
    do_req(16'h0404, 1'b0, 32'h0, 32'h44444444, 1'b0);
    do_req(16'h0504, 1'b0, 32'h0, 32'h55555555, 1'b0);
    chk("dirty_ev_rw",   32'(obs_mrw),   32'd1);
    chk("dirty_ev_addr", 32'(obs_maddr), 32'h0104);
    chk("dirty_ev_data", obs_mdata,      32'h12345678);
    do_req(16'h0604, 1'b0, 32'h0, 32'h66666666, 1'b0);
    chk("clean_ev_rw",   32'(obs_mrw),   32'd0);
    chk("clean_ev_addr", 32'(obs_maddr), 32'h0204);

    // store miss, hit, and its later write-back
    do_req(16'h2008, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    chk("store_miss_ready", 32'(obs_ready), 32'd0);
    do_req(16'h2008, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("store_miss_hit",  32'(obs_ready), 32'd1);
    chk("store_miss_data", bus_if.cpu_res.data, 32'hCAFEF00D);
    do_req(16'h2108, 1'b0, 32'h0, 32'h21212121, 1'b0);
    do_req(16'h2208, 1'b0, 32'h0, 32'h22222222, 1'b0);
    do_req(16'h2308, 1'b0, 32'h0, 32'h23232323, 1'b0);
    do_req(16'h2408, 1'b0, 32'h0, 32'h24242424, 1'b0);
    chk("store_wb_rw",   32'(obs_mrw),   32'd1);
    chk("store_wb_addr", 32'(obs_maddr), 32'h2008);
    chk("store_wb_data", obs_mdata,      32'hCAFEF00D);

    // reset in the middle of a fill wipes the array
    do_req(16'h0104, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(16'h0104, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("pre_reset_hit", 32'(obs_ready), 32'd1);
    do_req(16'h0708, 1'b0, 32'h0, 32'h0, 1'b1);
    do_req(16'h0104, 1'b0, 32'h0, 32'h01010101, 1'b0);
    chk("post_reset_miss", 32'(obs_ready), 32'd0);

    // randomized traffic over a few sets and tags
    for (int t = 0; t < 250; t++) begin
      a  = {8'(8'h10 + ($urandom % 6)), 6'(idx_opts[$urandom % 4]), 2'b00};
      r  = 1'($urandom % 2);
      wd = $urandom;
      do_req(a, r, wd, r ? wd : $urandom, 1'b0);
      repeat ($urandom % 3) begin
        bus_if.mem_data.ready = 1'($urandom % 2);
        step();
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
